// File: rtl/bootram_bus_adapter.sv
// bootram_bus_adapter
// Bridges a picorv32-style native memory bus (valid/ready + byte strobes) onto
// four 2Kx8 single-port boot RAM byte lanes forming a 32-bit boot memory.
// Every output is registered, so there is no combinational path from mem_* to ram_*.
// Optional feature: define BOOTRAM_WP_EN to write-protect the RAM. Writes still
// complete with a mem_ready pulse, but the RAM is not touched and wr_err latches high.
module bootram_bus_adapter #(
   parameter int AW         = 11,
   parameter int RDATA_HOLD = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [31:0]   mem_addr,
   input  logic [31:0]   mem_wdata,
   input  logic [3:0]    mem_wstrb,
   output logic [31:0]   mem_rdata,
   output logic          ram_ce,
   output logic          ram_oce,
   output logic [3:0]    ram_wre,
   output logic [AW-1:0] ram_ad,
   output logic [31:0]   ram_din,
   input  logic [31:0]   ram_dout,
   output logic          wr_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic            mem_ready_reg, mem_ready_next;
   logic [31:0]     mem_rdata_reg, mem_rdata_next;
   logic            ram_ce_reg, ram_ce_next;
   logic [3:0]      ram_wre_reg, ram_wre_next;
   logic [AW-1:0]   ram_ad_reg, ram_ad_next;
   logic [31:0]     ram_din_reg, ram_din_next;
   logic            wr_err_reg, wr_err_next;
   // Remembers whether the accepted request was a write. ram_wre cannot be
   // used for this, because write protection forces it to zero.
   logic            is_write_reg, is_write_next;

   // The byte-offset bits and the bits above the region are decoded upstream.
   logic            unused_addr;
   assign unused_addr = ^{mem_addr[1:0], mem_addr[31:AW+2]};

   // State and output registers; reset aborts any transaction without a mem_ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         mem_ready_reg <= 1'b0;
         mem_rdata_reg <= '0;
         ram_ce_reg    <= 1'b0;
         ram_wre_reg   <= '0;
         ram_ad_reg    <= '0;
         ram_din_reg   <= '0;
         wr_err_reg    <= 1'b0;
         is_write_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mem_ready_reg <= mem_ready_next;
         mem_rdata_reg <= mem_rdata_next;
         ram_ce_reg    <= ram_ce_next;
         ram_wre_reg   <= ram_wre_next;
         ram_ad_reg    <= ram_ad_next;
         ram_din_reg   <= ram_din_next;
         wr_err_reg    <= wr_err_next;
         is_write_reg  <= is_write_next;
      end
   end

   // Next-state and next-output logic: IDLE -> ACCESS -> (CAPTURE for reads) -> DONE -> IDLE.
   always_comb begin
      state_next     = state_reg;
      mem_ready_next = mem_ready_reg;
      mem_rdata_next = mem_rdata_reg;
      ram_ce_next    = ram_ce_reg;
      ram_wre_next   = ram_wre_reg;
      ram_ad_next    = ram_ad_reg;
      ram_din_next   = ram_din_reg;
      wr_err_next    = wr_err_reg;
      is_write_next  = is_write_reg;

      case (state_reg)
         IDLE: begin
            if (mem_valid && !mem_ready_reg) begin
               // Request fields are sampled only here; later bus changes are ignored.
               ram_ad_next   = mem_addr[AW+1:2];
               ram_din_next  = mem_wdata;
               is_write_next = |mem_wstrb;
`ifdef BOOTRAM_WP_EN
               // Writes never reach the RAM; reads still get their enable.
               ram_ce_next   = ~(|mem_wstrb);
               ram_wre_next  = '0;
`else
               ram_ce_next   = 1'b1;
               ram_wre_next  = mem_wstrb;
`endif
               state_next    = ACCESS;
            end
         end

         ACCESS: begin
            // The RAM performs its access on this edge; drop the enables afterwards.
            ram_ce_next  = 1'b0;
            ram_wre_next = '0;
            if (is_write_reg) begin
               mem_ready_next = 1'b1;
`ifdef BOOTRAM_WP_EN
               wr_err_next    = 1'b1;
`endif
               state_next     = DONE;
            end else begin
               state_next = CAPTURE;
            end
         end

         CAPTURE: begin
            // Read data from the RAM is valid one edge after its enabled edge.
            mem_rdata_next = ram_dout;
            mem_ready_next = 1'b1;
            state_next     = DONE;
         end

         DONE: begin
            mem_ready_next = 1'b0;
            if (RDATA_HOLD == 0) begin
               mem_rdata_next = '0;
            end
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mem_ready = mem_ready_reg;
   assign mem_rdata = mem_rdata_reg;
   assign ram_ce    = ram_ce_reg;
   assign ram_oce   = 1'b1;
   assign ram_wre   = ram_wre_reg;
   assign ram_ad    = ram_ad_reg;
   assign ram_din   = ram_din_reg;
   assign wr_err    = wr_err_reg;

endmodule

// File: tb/tb_bootram_bus_adapter.sv
// Testbench for bootram_bus_adapter: directed and random bus traffic, a
// behavioural model of the four byte-lane RAMs, a flat byte-array reference
// memory and scoreboards for mem_ready/mem_rdata and the RAM enable pulses.
// Build with BOOTRAM_WP_EN defined to exercise write protection.
module tb_bootram_bus_adapter;
   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_valid;
   logic          mem_ready;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wstrb;
   logic [31:0]   mem_rdata;
   logic          ram_ce;
   logic          ram_oce;
   logic [3:0]    ram_wre;
   logic [AW-1:0] ram_ad;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout;
   logic          wr_err;

   always #5 clk = ~clk;

   bootram_bus_adapter #(.AW(AW), .RDATA_HOLD(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .ram_ce    (ram_ce),
      .ram_oce   (ram_oce),
      .ram_wre   (ram_wre),
      .ram_ad    (ram_ad),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .wr_err    (wr_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural byte-lane RAMs: registered read, per-lane write enables.
   logic [7:0] lane_mem [4][2048];
   always @(posedge clk) begin
      if (ram_ce) begin
         for (int n = 0; n < 4; n++) begin
            ram_dout[8*n +: 8] <= lane_mem[n][ram_ad];
            if (ram_wre[n]) lane_mem[n][ram_ad] = ram_din[8*n +: 8];
         end
      end
   end

   // Reference: flat 8 KB byte memory; bus addresses alias modulo 8192.
   logic [7:0] ref_mem [8192];

   typedef struct {
      bit          is_write;
      logic [31:0] rdata;
      int          cyc;
   } rsp_t;
   typedef struct {
      int            cyc;
      logic [AW-1:0] ad;
      logic [3:0]    wre;
      logic [31:0]   din;
   } ce_t;

   rsp_t rsp_q[$];
   ce_t  ce_q[$];
   bit   exp_wr_err = 1'b0;

   // Monitor: compares every mem_ready and ram_ce pulse against the queued expectations.
   always @(negedge clk) begin : monitor
      rsp_t r;
      ce_t  e;
      if (reset) begin
         rsp_q.delete();
         ce_q.delete();
         exp_wr_err = 1'b0;
      end else begin
         check(ram_oce == 1'b1, "ram_oce", {31'd0, ram_oce}, 32'd1);
         if (mem_ready) begin
            if (rsp_q.size() == 0) begin
               check(1'b0, "unexpected_ready", {31'd0, mem_ready}, 32'd0);
            end else begin
               r = rsp_q.pop_front();
               check(cyc == r.cyc, "ready_cycle", cyc, r.cyc);
               if (r.is_write) begin
`ifdef BOOTRAM_WP_EN
                  exp_wr_err = 1'b1;
`endif
               end else begin
                  check(mem_rdata == r.rdata, "rdata", mem_rdata, r.rdata);
               end
               check(wr_err == exp_wr_err, "wr_err", {31'd0, wr_err}, {31'd0, exp_wr_err});
            end
         end
         if (ram_ce) begin
            if (ce_q.size() == 0) begin
               check(1'b0, "unexpected_ram_ce", {31'd0, ram_ce}, 32'd0);
            end else begin
               e = ce_q.pop_front();
               check(cyc == e.cyc, "ram_ce_cycle", cyc, e.cyc);
               check(ram_ad == e.ad, "ram_ad", {21'd0, ram_ad}, {21'd0, e.ad});
               check(ram_wre == e.wre, "ram_wre", {28'd0, ram_wre}, {28'd0, e.wre});
               if (e.wre != 4'd0) check(ram_din == e.din, "ram_din", ram_din, e.din);
            end
         end
      end
   end

   // Issue one request; expectations are derived from the flat reference memory.
   // Called and returns at 1 time unit after a rising edge with the DUT in IDLE.
   task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input bit drop_valid, input bit scramble);
      int          c;
      int          waited;
      int          base;
      rsp_t        r;
      ce_t         e;
      logic [31:0] word;
      c    = cyc;
      base = int'(addr[12:2]) * 4;
      for (int n = 0; n < 4; n++) word[8*n +: 8] = ref_mem[base + n];
      r.is_write = (wstrb != 4'd0);
      r.rdata    = word;
      r.cyc      = r.is_write ? c + 2 : c + 3;
      e.cyc      = c + 1;
      e.ad       = addr[AW+1:2];
      e.wre      = wstrb;
      e.din      = wdata;
`ifdef BOOTRAM_WP_EN
      if (!r.is_write) ce_q.push_back(e);
`else
      ce_q.push_back(e);
      for (int n = 0; n < 4; n++) if (wstrb[n]) ref_mem[base + n] = wdata[8*n +: 8];
`endif
      rsp_q.push_back(r);
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      @(posedge clk); #1;
      if (scramble) begin
         mem_addr  = $urandom;
         mem_wdata = $urandom;
         mem_wstrb = 4'($urandom);
      end
      if (drop_valid) mem_valid = 1'b0;
      waited = 0;
      while (!mem_ready && waited < 8) begin
         @(posedge clk); #1;
         waited++;
      end
      check(mem_ready == 1'b1, "ready_timeout", {31'd0, mem_ready}, 32'd1);
      mem_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check(mem_ready == 1'b0, {tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
      check(mem_rdata == 32'd0, {tag, "_mem_rdata"}, mem_rdata, 32'd0);
      check(ram_ce == 1'b0, {tag, "_ram_ce"}, {31'd0, ram_ce}, 32'd0);
      check(ram_wre == 4'd0, {tag, "_ram_wre"}, {28'd0, ram_wre}, 32'd0);
      check(ram_ad == '0, {tag, "_ram_ad"}, {21'd0, ram_ad}, 32'd0);
      check(ram_din == 32'd0, {tag, "_ram_din"}, ram_din, 32'd0);
      check(wr_err == 1'b0, {tag, "_wr_err"}, {31'd0, wr_err}, 32'd0);
      check(ram_oce == 1'b1, {tag, "_ram_oce"}, {31'd0, ram_oce}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0]  b;
      logic [31:0] a;
      logic [10:0] w;
      for (int wi = 0; wi < 2048; wi++) begin
         for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            lane_mem[n][wi]       = b;
            ref_mem[wi * 4 + n]   = b;
         end
      end
      reset     = 1'b1;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
      end
      check_idle_outputs("reset");

      // Directed sequence
      do_req(32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
      do_req(32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
      do_req(32'h0000_0010, 32'h11223344, 4'b0110, 1'b0, 1'b0);
      do_req(32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
      do_req(32'h0000_2010, 32'h0, 4'h0, 1'b0, 1'b0);
      do_req(32'hFFFF_E013, 32'h0, 4'h0, 1'b1, 1'b1);
      do_req(32'h0000_1FFC, 32'hCAFEF00D, 4'b1001, 1'b1, 1'b1);
      do_req(32'h0000_1FFC, 32'h0, 4'h0, 1'b0, 1'b0);

      // Reset during ACCESS of a read: the request is aborted without mem_ready.
      begin
         ce_t e;
         e.cyc = cyc + 1; e.ad = 11'd4; e.wre = 4'd0; e.din = 32'd0;
         ce_q.push_back(e);
         mem_valid = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'd0;
         @(posedge clk); #1;
         reset = 1'b1; mem_valid = 1'b0;
         @(posedge clk); #1;
         check_idle_outputs("abort");
         reset = 1'b0;
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
         end
      end

      do_req(32'h0000_0010, 32'h12345678, 4'hF, 1'b0, 1'b0);
      do_req(32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);

      // Random traffic over a small, aliased set of words so reads hit earlier writes.
      for (int t = 0; t < 150; t++) begin
         a = $urandom;
         if ($urandom_range(0, 3) == 0) w = 11'($urandom);
         else if ($urandom_range(0, 1) == 0) w = 11'($urandom_range(0, 7));
         else w = 11'h7F8 + 11'($urandom_range(0, 7));
         a[12:2] = w;
         do_req(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (6) @(posedge clk);
      #1;
      check(rsp_q.size() == 0, "rsp_queue_drained", rsp_q.size(), 32'd0);
      check(ce_q.size() == 0, "ce_queue_drained", ce_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
